// File: rtl/insn_queue_pkg.sv
// Shared types for the decode-to-dispatch instruction queue.
// Optional combinational bypass when empty is enabled by IQ_BYPASS_EN.
package insn_queue_pkg;

  localparam int IQ_DEPTH_DEF = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } decoded_pack_t;

  typedef struct packed {
    decoded_pack_t pack;
    logic          branch;
  } iq_entry_t;

endpackage

// File: rtl/insn_queue.sv
// FIFO between decoder and dispatcher; squash from the ROB empties it.
// Define IQ_BYPASS_EN for zero-latency pass-through when empty.
module insn_queue
  import insn_queue_pkg::*;
#(
  parameter  int IQ_DEPTH   = IQ_DEPTH_DEF,
  localparam int IQ_PTR_LEN = $clog2(IQ_DEPTH),
  localparam int IQ_CNT_LEN = $clog2(IQ_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  squash,
  input  logic                  in_valid,
  input  decoded_pack_t         in_pack,
  input  logic                  in_branch,
  input  logic                  dispatch_stall,
  output logic                  out_valid,
  output decoded_pack_t         out_pack,
  output logic                  out_branch,
  output logic                  full,
  output logic [IQ_CNT_LEN-1:0] count
);

  iq_entry_t             mem_q [IQ_DEPTH];
  logic [IQ_PTR_LEN-1:0] head_q;
  logic [IQ_PTR_LEN-1:0] tail_q;
  logic [IQ_CNT_LEN-1:0] count_q;

  logic empty;
  logic byp;
  logic byp_take;
  logic enq;
  logic deq;

  assign empty = (count_q == '0);
  assign full  = (count_q == IQ_CNT_LEN'(IQ_DEPTH));
  assign count = count_q;

`ifdef IQ_BYPASS_EN
  assign byp      = empty & in_valid & ~squash;
  assign byp_take = byp & ~dispatch_stall;
`else
  assign byp      = 1'b0;
  assign byp_take = 1'b0;
`endif

  // A bypassed instruction consumed this cycle is never written.
  assign enq = in_valid & ~full & ~squash & ~byp_take;
  assign deq = ~empty & ~dispatch_stall & ~squash;

  assign out_valid = ~empty | byp;

  always_comb begin
    out_pack   = '0;
    out_branch = 1'b0;
    if (byp) begin
      out_pack   = in_pack;
      out_branch = in_branch;
    end else if (~empty) begin
      out_pack   = mem_q[head_q].pack;
      out_branch = mem_q[head_q].branch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq) begin
      mem_q[tail_q] <= '{pack: in_pack, branch: in_branch};
    end
  end

  // Depth is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (reset || squash) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + IQ_PTR_LEN'(1);
      if (deq) head_q <= head_q + IQ_PTR_LEN'(1);
      unique case ({enq, deq})
        2'b10:   count_q <= count_q + IQ_CNT_LEN'(1);
        2'b01:   count_q <= count_q - IQ_CNT_LEN'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
